// File: rtl/aes_key_pkg.sv
// Shared types and constants for the AES-128 key schedule sequencer:
// FSM states, round count, key width and the Rcon round constants.
package aes_key_pkg;

  localparam int NR    = 10;
  localparam int KEY_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } ks_state_e;

  // Rcon[1] is the most significant byte, Rcon[10] the least.
  localparam logic [8*NR-1:0] RCON_BYTES = 80'h01_02_04_08_10_20_40_80_1b_36;

  function automatic logic [31:0] rcon_word(input logic [3:0] round);
    if (round >= 4'd1 && round <= 4'd10)
      return {RCON_BYTES[8*(NR - int'(round)) +: 8], 24'h0};
    return 32'h0;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational byte substitution.
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so entry x starts at bit 8*(255-x) = {~x,3'b0}.
  assign y = SBOX[{~x, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key expansion sequencer streaming round keys 0..10 over valid/ready.
// Optional KEY_SCHED_STORE_EN keeps all eleven round keys readable via rd_round/rd_key.
module aes_key_sched_ctrl
  import aes_key_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [3:0]       rk_round,
  output logic [KEY_W-1:0] rk_out,
  output logic             done,
  input  logic [3:0]       rd_round,
  output logic [KEY_W-1:0] rd_key
);

  ks_state_e        state_q, state_d;
  logic [KEY_W-1:0] rk_out_q, rk_out_d;
  logic [3:0]       rk_round_q, rk_round_d;
  logic             busy_q, busy_d;
  logic             rk_valid_q, rk_valid_d;
  logic             done_q, done_d;

  logic             xfer;
  logic [31:0]      rot_w, sub_w, t_w;
  logic [31:0]      n0, n1, n2, n3;

  assign xfer  = rk_valid_q && rk_ready;
  assign rot_w = {rk_out_q[23:0], rk_out_q[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .x (rot_w[8*g +: 8]),
      .y (sub_w[8*g +: 8])
    );
  end

  // Next round key: one SubWord/Rcon step followed by the chained word XORs.
  assign t_w = sub_w ^ rcon_word(rk_round_q + 4'd1);
  assign n0  = rk_out_q[127:96] ^ t_w;
  assign n1  = rk_out_q[95:64]  ^ n0;
  assign n2  = rk_out_q[63:32]  ^ n1;
  assign n3  = rk_out_q[31:0]   ^ n2;

  always_comb begin
    state_d    = state_q;
    rk_out_d   = rk_out_q;
    rk_round_d = rk_round_q;
    busy_d     = busy_q;
    rk_valid_d = rk_valid_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rk_out_d   = key_in;
          rk_round_d = 4'd0;
          rk_valid_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = EMIT;
        end
      end
      EMIT: begin
        if (xfer) begin
          if (rk_round_q == 4'(NR)) begin
            rk_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = DONE;
          end else begin
            rk_out_d   = {n0, n1, n2, n3};
            rk_round_d = rk_round_q + 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rk_out_q   <= '0;
      rk_round_q <= '0;
      busy_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rk_out_q   <= rk_out_d;
      rk_round_q <= rk_round_d;
      busy_q     <= busy_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign rk_valid = rk_valid_q;
  assign rk_round = rk_round_q;
  assign rk_out   = rk_out_q;
  assign done     = done_q;

`ifdef KEY_SCHED_STORE_EN
  // Key store is deliberately left out of reset; it is fully rewritten by every expansion.
  logic [KEY_W-1:0] store_q [0:NR];

  always_ff @(posedge clk) begin
    if (xfer) store_q[rk_round_q] <= rk_out_q;
  end

  always_comb begin
    rd_key = '0;
    if (rd_round <= 4'(NR)) rd_key = store_q[rd_round];
  end
`else
  logic unused_rd_round;
  assign unused_rd_round = ^rd_round;
  assign rd_key          = '0;
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Randomized bench for aes_key_sched_ctrl against a word-array AES-128 key expansion model
// whose S-box is derived from GF(2^8) inversion plus the affine transform.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         reset, start, rk_ready;
  logic         busy, rk_valid, done;
  logic [127:0] key_in, rk_out, rd_key;
  logic [3:0]   rk_round, rd_round;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0]   sb [0:255];
  logic [127:0] exp_rk [0:10];
  logic [127:0] got [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  always #5 clk = ~clk;

  aes_key_sched_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_round (rk_round),
    .rk_out   (rk_out),
    .done     (done),
    .rd_round (rd_round),
    .rd_key   (rd_key)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ aa;
      aa = xtime(aa);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Starts from IDLE at a negedge; ends at the DONE-cycle negedge (hold) or back in IDLE.
  task automatic run_exp(input logic [127:0] key, input int stall_pct, input int stall_at,
                         input bit hold, input string tag);
    int idx = 0;
    int cyc = 0;
    int st_cnt = 0;
    bit rdy;
    model_expand(key);
    start  = 1'b1;
    key_in = key;
    @(negedge clk);
    if (!hold) start = 1'b0;
    key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    while (idx <= 10 && cyc < 300) begin
      chk({tag, "_valid"}, 128'(rk_valid), 128'(1));
      chk({tag, "_busy"},  128'(busy),     128'(1));
      chk({tag, "_done0"}, 128'(done),     128'(0));
      chk({tag, "_round"}, 128'(rk_round), 128'(idx));
      chk({tag, "_key"},   rk_out,         exp_rk[idx]);
      got[idx] = rk_out;
      rdy = ($urandom_range(99) >= stall_pct);
      if (idx == stall_at && st_cnt < 3) begin
        rdy = 1'b0;
        st_cnt++;
      end
      if (!hold) start = ($urandom_range(7) == 0);
      rk_ready = rdy;
      @(negedge clk);
      if (rdy) idx++;
      cyc++;
    end
    chk({tag, "_rounds_seen"}, 128'(idx), 128'(11));
    chk({tag, "_done"},        128'(done),     128'(1));
    chk({tag, "_busy_end"},    128'(busy),     128'(0));
    chk({tag, "_valid_end"},   128'(rk_valid), 128'(0));
    if (!hold) begin
      start = 1'b1;
      @(negedge clk);
      chk({tag, "_idle_valid"}, 128'(rk_valid), 128'(0));
      chk({tag, "_one_done"},   128'(done),     128'(0));
      chk({tag, "_idle_busy"},  128'(busy),     128'(0));
      start = 1'b0;
    end
  endtask

  initial begin
    int cyc;
    reset    = 1'b0;
    start    = 1'b0;
    rk_ready = 1'b0;
    key_in   = '0;
    rd_round = 4'd0;
    build_sbox();
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy",  128'(busy),     128'(0));
    chk("rst_valid", 128'(rk_valid), 128'(0));
    chk("rst_done",  128'(done),     128'(0));
    chk("rst_round", 128'(rk_round), 128'(0));
    chk("rst_key",   rk_out,         128'(0));
    chk("rst_rdkey", rd_key,         128'(0));
    reset = 1'b0;
    @(negedge clk);

    run_exp(FIPS_KEY, 0, -1, 1'b0, "fips");
    chk("fips_r1",  got[1],  128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`ifdef KEY_SCHED_STORE_EN
    rd_round = 4'd10; #1 chk("store_r10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_round = 4'd0;  #1 chk("store_r0",  rd_key, FIPS_KEY);
    rd_round = 4'd12; #1 chk("store_r12", rd_key, 128'(0));
`else
    for (int i = 0; i < 4; i++) begin
      rd_round = 4'($urandom_range(15));
      #1 chk("rdkey_tied", rd_key, 128'(0));
    end
`endif
    @(negedge clk);

    run_exp(FIPS_KEY, 0, 4, 1'b0, "stall");
    chk("stall_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset mid-expansion while round 6 is presented.
    start  = 1'b1;
    key_in = FIPS_KEY;
    @(negedge clk);
    start    = 1'b0;
    rk_ready = 1'b1;
    cyc      = 0;
    while (rk_round != 4'd6 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reach_r6", 128'(rk_round), 128'(6));
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy",  128'(busy),     128'(0));
    chk("mid_rst_valid", 128'(rk_valid), 128'(0));
    chk("mid_rst_round", 128'(rk_round), 128'(0));
    chk("mid_rst_key",   rk_out,         128'(0));
    chk("mid_rst_done",  128'(done),     128'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_exp(128'h0, 20, -1, 1'b0, "zero");
    chk("zero_r1", got[1], 128'h62636363626363636263636362636363);

    // Start held high across two back-to-back expansions.
    begin
      logic [127:0] k1, k2;
      k1 = {$urandom(), $urandom(), $urandom(), $urandom()};
      k2 = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_exp(k1, 0, -1, 1'b1, "hold1");
      key_in = k2;
      @(negedge clk);
      chk("hold_idle_valid", 128'(rk_valid), 128'(0));
      chk("hold_idle_done",  128'(done),     128'(0));
      run_exp(k2, 0, -1, 1'b0, "hold2");
      chk("hold2_r0", got[0], k2);
    end

    for (int n = 0; n < 6; n++) begin
      run_exp({$urandom(), $urandom(), $urandom(), $urandom()}, 35, -1, 1'b0, "rand");
      repeat ($urandom_range(2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
